// File: rtl/aes_ctrl_ti2_pkg.sv
//------------------------------------------------------------------------------
// aes_ctrl_ti2_pkg : shared types and constants for the two-share AES controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package aes_ctrl_ti2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RBYTE = 3'd2,
        ST_MIX   = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    localparam int         BYTES_PER_STATE = 16;
    localparam int         MIX_CYCLES      = 4;
    localparam logic [7:0] RCON_INIT       = 8'h01;
    localparam logic [7:0] RCON_POLY       = 8'h1B;

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_SBOX = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    // GF(2^8) multiply-by-x, used to step the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_ctrl_ti2_if.sv
//------------------------------------------------------------------------------
// aes_ctrl_ti2_if : handshake and strobe bundle between controller and datapath
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface aes_ctrl_ti2_if;
    logic       StartxSI;
    logic       BusyxSO;
    logic       DonexSO;
    logic       ShiftRowsxSO;
    logic       MixColumnsxSO;
    logic       NineRoundxSO;
    logic [1:0] SelInxSO;
    logic [3:0] ByteCntxDO;
    logic [3:0] RoundxDO;
    logic [7:0] RconxDO;
    logic       KeyEnxSO;
    logic       OutValidxSO;

    modport master (
        output StartxSI,
        input  BusyxSO, DonexSO, ShiftRowsxSO, MixColumnsxSO, NineRoundxSO,
               SelInxSO, ByteCntxDO, RoundxDO, RconxDO, KeyEnxSO, OutValidxSO
    );

    modport slave (
        input  StartxSI,
        output BusyxSO, DonexSO, ShiftRowsxSO, MixColumnsxSO, NineRoundxSO,
               SelInxSO, ByteCntxDO, RoundxDO, RconxDO, KeyEnxSO, OutValidxSO
    );
endinterface

`default_nettype wire

// File: rtl/aes_ctrl_ti2_rcon_gen.sv
//------------------------------------------------------------------------------
// aes_ctrl_ti2_rcon_gen : registered AES round constant with load/advance
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aes_ctrl_ti2_rcon_gen
    import aes_ctrl_ti2_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       load,
    input  wire logic       advance,
    output logic      [7:0] rcon
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcon <= RCON_INIT;
        end else if (load) begin
            rcon <= RCON_INIT;
        end else if (advance) begin
            rcon <= xtime(rcon);
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_ctrl_ti2.sv
//------------------------------------------------------------------------------
// aes_ctrl_ti2 : sequencer for the byte-serial two-share threshold AES-128 core
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aes_ctrl_ti2
    import aes_ctrl_ti2_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int SR_BYTE    = 15
) (
    input  wire logic     ClkxCI,
    input  wire logic     RstxBI,
    aes_ctrl_ti2_if.slave ctrl
);

    localparam logic [3:0] LAST_BYTE  = 4'(BYTES_PER_STATE - 1);
    localparam logic [3:0] MIX_LAST   = 4'(MIX_CYCLES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] SR_IDX     = 4'(SR_BYTE);

    state_t     state, state_nxt;
    logic [3:0] byte_cnt, cnt_nxt;
    logic [3:0] round, round_nxt;
    logic       rcon_load, rcon_adv, done_nxt;
    logic       busy, done, shift_rows, mix_cols, nine, key_en, out_valid;
    logic [1:0] sel_in;
    logic [7:0] rcon;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = byte_cnt;
        round_nxt = round;
        rcon_load = 1'b0;
        rcon_adv  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl.StartxSI) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = 4'd0;
                    round_nxt = 4'd0;
                    rcon_load = 1'b1;
                end
            end
            ST_LOAD: begin
                cnt_nxt = byte_cnt + 4'd1;
                if (byte_cnt == LAST_BYTE) begin
                    state_nxt = ST_RBYTE;
                    cnt_nxt   = 4'd0;
                end
            end
            ST_RBYTE: begin
                cnt_nxt = byte_cnt + 4'd1;
                if (byte_cnt == LAST_BYTE) begin
                    state_nxt = ST_MIX;
                    cnt_nxt   = 4'd0;
                end
            end
            ST_MIX: begin
                cnt_nxt = byte_cnt + 4'd1;
                if (byte_cnt == MIX_LAST) begin
                    cnt_nxt = 4'd0;
                    if (round == LAST_ROUND) begin
                        state_nxt = ST_OUT;
                    end else begin
                        state_nxt = ST_RBYTE;
                        round_nxt = round + 4'd1;
                        rcon_adv  = 1'b1;
                    end
                end
            end
            ST_OUT: begin
                cnt_nxt = byte_cnt + 4'd1;
                if (byte_cnt == LAST_BYTE) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 4'd0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they line up with the
    // registered state and counters in the same cycle.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state      <= ST_IDLE;
            byte_cnt   <= 4'd0;
            round      <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            shift_rows <= 1'b0;
            mix_cols   <= 1'b0;
            nine       <= 1'b0;
            key_en     <= 1'b0;
            out_valid  <= 1'b0;
            sel_in     <= SEL_LOAD;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= cnt_nxt;
            round      <= round_nxt;
            busy       <= (state_nxt != ST_IDLE);
            done       <= done_nxt;
            shift_rows <= (state_nxt == ST_RBYTE) && (cnt_nxt == SR_IDX);
            mix_cols   <= (state_nxt == ST_MIX);
            nine       <= (state_nxt == ST_MIX) && (round_nxt == LAST_ROUND);
            key_en     <= (state_nxt == ST_LOAD) || (state_nxt == ST_RBYTE) ||
                          (state_nxt == ST_OUT);
            out_valid  <= (state_nxt == ST_OUT);
            case (state_nxt)
                ST_RBYTE, ST_MIX: sel_in <= SEL_SBOX;
                ST_OUT:           sel_in <= SEL_ZERO;
                default:          sel_in <= SEL_LOAD;
            endcase
        end
    end

    aes_ctrl_ti2_rcon_gen u_rcon_gen (
        .clk     (ClkxCI),
        .rst_n   (RstxBI),
        .load    (rcon_load),
        .advance (rcon_adv),
        .rcon    (rcon)
    );

    assign ctrl.BusyxSO       = busy;
    assign ctrl.DonexSO       = done;
    assign ctrl.ShiftRowsxSO  = shift_rows;
    assign ctrl.MixColumnsxSO = mix_cols;
    assign ctrl.NineRoundxSO  = nine;
    assign ctrl.SelInxSO      = sel_in;
    assign ctrl.ByteCntxDO    = byte_cnt;
    assign ctrl.RoundxDO      = round;
    assign ctrl.RconxDO       = rcon;
    assign ctrl.KeyEnxSO      = key_en;
    assign ctrl.OutValidxSO   = out_valid;

endmodule

`default_nettype wire

// File: tb/tb_aes_ctrl_ti2.sv
//------------------------------------------------------------------------------
// tb_aes_ctrl_ti2 : self-checking bench comparing the controller to a timeline model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_ctrl_ti2;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    aes_ctrl_ti2_if bus ();

    aes_ctrl_ti2 #(.NUM_ROUNDS(10), .SR_BYTE(15)) dut (
        .ClkxCI (clk),
        .RstxBI (rst_n),
        .ctrl   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] RCON_TBL [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    typedef struct packed {
        logic       busy, done, sr, mc, nine, key, ov;
        logic [1:0] sel;
        logic [3:0] cnt, rnd;
        logic [7:0] rcon;
    } exp_t;

    // Expected outputs t cycles after the edge that accepted start:
    // 16 load, 10 rounds of (16 byte + 4 mix), 16 out, then the done cycle.
    function automatic exp_t model(input int t);
        exp_t e;
        int   u, r, p;
        e      = '0;
        e.rcon = RCON_TBL[0];
        if (t >= 1 && t <= 16) begin
            e.busy = 1'b1; e.key = 1'b1; e.sel = 2'b00; e.cnt = 4'(t - 1);
        end else if (t >= 17 && t <= 216) begin
            u = t - 17; r = u / 20; p = u % 20;
            e.busy = 1'b1; e.sel = 2'b01; e.rnd = 4'(r); e.rcon = RCON_TBL[r];
            if (p < 16) begin
                e.key = 1'b1; e.cnt = 4'(p); e.sr = (p == 15);
            end else begin
                e.mc = 1'b1; e.cnt = 4'(p - 16); e.nine = (r == 9);
            end
        end else if (t >= 217 && t <= 232) begin
            e.busy = 1'b1; e.key = 1'b1; e.ov = 1'b1; e.sel = 2'b11;
            e.cnt = 4'(t - 217); e.rnd = 4'd9; e.rcon = RCON_TBL[9];
        end else begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic cmp(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        cmp({tag, "_busy"}, 0, 32'(bus.BusyxSO), 32'd0);
        cmp({tag, "_done"}, 0, 32'(bus.DonexSO), 32'd0);
        cmp({tag, "_sr"},   0, 32'(bus.ShiftRowsxSO), 32'd0);
        cmp({tag, "_mc"},   0, 32'(bus.MixColumnsxSO), 32'd0);
        cmp({tag, "_nine"}, 0, 32'(bus.NineRoundxSO), 32'd0);
        cmp({tag, "_key"},  0, 32'(bus.KeyEnxSO), 32'd0);
        cmp({tag, "_ov"},   0, 32'(bus.OutValidxSO), 32'd0);
        cmp({tag, "_sel"},  0, 32'(bus.SelInxSO), 32'd0);
        cmp({tag, "_cnt"},  0, 32'(bus.ByteCntxDO), 32'd0);
        cmp({tag, "_rnd"},  0, 32'(bus.RoundxDO), 32'd0);
        cmp({tag, "_rcon"}, 0, 32'(bus.RconxDO), 32'h01);
    endtask

    // Entered at t=1 (just after the accepting edge). mode 0: start low,
    // 1: start held high, 2: random start noise while busy. abort_t>0
    // asserts reset asynchronously in that cycle.
    task automatic do_run(input int mode, input int abort_t);
        exp_t e;
        int   n_sr = 0, n_mc = 0;
        bit   aborted = 0;
        for (int t = 1; t <= 233; t++) begin
            e = model(t);
            cmp("busy", t, 32'(bus.BusyxSO), 32'(e.busy));
            cmp("done", t, 32'(bus.DonexSO), 32'(e.done));
            cmp("shiftrows", t, 32'(bus.ShiftRowsxSO), 32'(e.sr));
            cmp("mixcols", t, 32'(bus.MixColumnsxSO), 32'(e.mc));
            cmp("nineround", t, 32'(bus.NineRoundxSO), 32'(e.nine));
            cmp("keyen", t, 32'(bus.KeyEnxSO), 32'(e.key));
            cmp("outvalid", t, 32'(bus.OutValidxSO), 32'(e.ov));
            cmp("selin", t, 32'(bus.SelInxSO), 32'(e.sel));
            if (t <= 232) begin
                cmp("bytecnt", t, 32'(bus.ByteCntxDO), 32'(e.cnt));
                cmp("round", t, 32'(bus.RoundxDO), 32'(e.rnd));
                cmp("rcon", t, 32'(bus.RconxDO), 32'(e.rcon));
            end
            if (bus.ShiftRowsxSO === 1'b1) n_sr++;
            if (bus.MixColumnsxSO === 1'b1) n_mc++;
            if (t == abort_t) begin
                #1 rst_n = 1'b0;
                #1 check_reset_vals("async_rst");
                bus.StartxSI = 1'b0;
                #1 rst_n = 1'b1;
                aborted = 1;
                break;
            end
            if (t == 233)      bus.StartxSI = (mode == 1);
            else if (mode == 2) bus.StartxSI = 1'($urandom_range(0, 1));
            else               bus.StartxSI = (mode == 1);
            @(posedge clk); #1;
        end
        if (!aborted) begin
            cmp("sr_per_run", 0, 32'(n_sr), 32'd10);
            cmp("mc_per_run", 0, 32'(n_mc), 32'd40);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cmp("idle_busy", i, 32'(bus.BusyxSO), 32'd0);
            cmp("idle_done", i, 32'(bus.DonexSO), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic start_run(input int mode, input int abort_t);
        bus.StartxSI = 1'b1;
        @(posedge clk); #1;
        do_run(mode, abort_t);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.StartxSI = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle_cycles(int'($urandom_range(1, 5)));

        start_run(0, 0);                       // nominal single pulse
        idle_cycles(int'($urandom_range(1, 4)));
        start_run(2, 0);                       // start noise while busy
        idle_cycles(int'($urandom_range(1, 4)));
        start_run(1, 0);                       // start held: restarts after done
        do_run(0, 0);
        idle_cycles(2);
        start_run(0, 17 + 5 * 20 + 16 + int'($urandom_range(0, 3)));  // reset in round 5 MIX
        idle_cycles(int'($urandom_range(1, 3)));
        start_run(0, 0);
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_ctrl_ti2.md
Name: aes_ctrl_ti2

Overview:
- Sequencing controller for the byte-serial, two-share threshold AES-128 encryption core.
- Drives the shift/ShiftRows/MixColumns/last-round strobes of both share state-register banks, the state input-mux select, and the key-schedule strobes and Rcon.
- Provides a start/busy/done handshake to the top level.
- One instance is shared by all share banks, so all banks shift in lockstep.

Parameters:
- NUM_ROUNDS, 10: number of AES rounds; the last round index is NUM_ROUNDS-1.
- SR_BYTE, 15: byte-counter value of the round-byte phase at which ShiftRowsxSO is asserted.

Ports:
- ClkxCI  in  1  clock
- RstxBI  in  1  asynchronous active-low reset
- StartxSI  in  1  start pulse; sampled only in IDLE
- BusyxSO  out  1  high while an encryption is in progress
- DonexSO  out  1  one-cycle pulse when the ciphertext has been fully streamed out
- ShiftRowsxSO  out  1  to the state-register ShiftRows strobe
- MixColumnsxSO  out  1  to the state-register MixColumns strobe
- NineRoundxSO  out  1  last-round flag to the state registers
- SelInxSO  out  2  state input-mux select: 00 plaintext^key load, 01 S-box path, 11 zero feed
- ByteCntxDO  out  4  byte index within the current phase
- RoundxDO  out  4  current round index, 0..NUM_ROUNDS-1
- RconxDO  out  8  round constant for the key schedule
- KeyEnxSO  out  1  key-schedule byte advance
- OutValidxSO  out  1  state output byte is a valid ciphertext byte

Behaviour:
- Reset (asynchronous, active-low), also mid-operation:
  - FSM goes to IDLE; ByteCnt=0, Round=0, Rcon=0x01.
  - All 1-bit outputs are 0; SelIn=00.
  - Reset takes effect immediately, without a clock edge.
- States: IDLE, LOAD, RBYTE, MIX, OUT.
- IDLE:
  - StartxSI=1 at edge k moves the FSM to LOAD; ByteCnt=0, Round=0, Rcon=0x01.
  - StartxSI in any other state is ignored.
- LOAD, 16 cycles:
  - SelIn=00, KeyEn=1.
  - When ByteCnt=15, move to RBYTE with ByteCnt=0.
- RBYTE, 16 cycles:
  - SelIn=01, KeyEn=1.
  - ShiftRowsxSO=1 only when ByteCnt==SR_BYTE.
  - When ByteCnt=15, move to MIX with ByteCnt=0.
- MIX, 4 cycles:
  - MixColumnsxSO=1, SelIn=01.
  - NineRoundxSO = (Round==NUM_ROUNDS-1). This is high for all 4 MIX cycles of the last round, so the state banks hold.
  - Timing is identical in every round.
  - When ByteCnt=3 and Round<NUM_ROUNDS-1:
    - Round increments.
    - Rcon <= xtime(Rcon): left shift, XOR 0x1B if msb was set.
    - Move to RBYTE.
  - When ByteCnt=3 and Round==NUM_ROUNDS-1: move to OUT with ByteCnt=0.
- OUT, 16 cycles:
  - OutValid=1, SelIn=11, KeyEn=1 (final round key streamed alongside).
  - When ByteCnt=15, move to IDLE and pulse DonexSO for exactly one cycle in the following IDLE cycle.
- Busy and latency:
  - BusyxSO=1 in LOAD/RBYTE/MIX/OUT, i.e. cycles k+1..k+232.
  - DonexSO=1 at cycle k+233.
  - Cycle count: 16 LOAD + 10×20 round cycles + 16 OUT.
- Round constants: Rcon per round 0..9 = 01,02,04,08,10,20,40,80,1B,36. Rcon resets to 0x01 on each accepted start.
- Counters:
  - ByteCnt is 4 bits and wraps only through the explicit phase-end resets above.
  - Round never exceeds NUM_ROUNDS-1.
- Output registration and exclusivity:
  - All outputs are decoded from registered state and counters, with no combinational path from StartxSI.
  - ShiftRowsxSO and MixColumnsxSO are never high together.

Decomposition:
- Shared package/header aes_ti_defs: FSM state encodings, BYTES_PER_STATE=16, MIX_CYCLES=4, RCON_INIT=8'h01, RCON_POLY=8'h1B, SelIn codes.
- One natural sub-module: aes_rcon_gen, a registered Rcon with load-init and xtime-advance enables.

Test Plan:
- Reset then a single StartxSI pulse at edge k -> BusyxSO rises at k+1, first ShiftRowsxSO at k+32, first MixColumnsxSO at k+33..k+36, DonexSO exactly at k+233, Busy low at k+233.
- Over a full run, sample RconxDO in each RBYTE phase -> sequence 01,02,04,08,10,20,40,80,1B,36; NineRoundxSO is high only during the 4 MIX cycles of round 9.
- Per round -> exactly one ShiftRows cycle at ByteCnt=15 and 4 MixColumns cycles; 10 of each per encryption; never both strobes in the same cycle.
- StartxSI held high for the entire run -> a single encryption completes; a new one starts only from the IDLE cycle after the Done pulse.
- RstxBI low asynchronously during round 5 MIX -> all outputs 0 and Rcon=01 immediately; a subsequent start gives nominal timing.
- Integrate with two aes_state_regs2-style banks plus the S-box and key schedule, on the FIPS-197 C.1 vector (key 000102..0f, plaintext 00112233..ff) -> XOR of the share outputs over the 16 OutValid cycles equals 69c4e0d86a7b0430d8cdb78070b4c55a.
